// File: rtl/hw_semaphore_pkg.sv
// hw_semaphore_pkg: shared constants and the round-robin pick helper for the
// hw_semaphore block.
//   HW_SEM_NUM_REQ_DEF    default requester count
//   HW_SEM_NUM_TOKENS_DEF default token pool size
//   STATS_W               width of the optional statistics counters
//   MAX_REQ               largest supported requester count (vector width of rr_pick)
//   rr_pick(eligible, ptr) one-hot of the first set bit at or after ptr, wrapping.
package hw_semaphore_pkg;

  localparam int HW_SEM_NUM_REQ_DEF    = 4;
  localparam int HW_SEM_NUM_TOKENS_DEF = 2;
  localparam int STATS_W               = 32;
  localparam int MAX_REQ               = 16;

  // Works on a fixed 16-bit vector. Callers zero the bits above their own
  // requester count and keep ptr below it, so wrapping modulo 16 gives the
  // same answer as wrapping modulo the real requester count.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] eligible,
                                                 input logic [3:0]         ptr);
    logic [MAX_REQ-1:0] pick;
    logic [3:0]         idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + 4'(k);
      if (!found && eligible[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker that owns the rotating priority pointer.
//   clk, reset_n  clock and asynchronous active-low reset
//   eligible      requesters that may be granted this cycle
//   enable        a pick is allowed this cycle (a token is free)
//   pick          one-hot winner, all zero when disabled or nothing eligible
// After a pick the pointer moves to winner + 1, wrapping to 0.
module rr_arbiter
  import hw_semaphore_pkg::*;
#(
  parameter int NUM_REQ = HW_SEM_NUM_REQ_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               enable,
  output logic [NUM_REQ-1:0] pick
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      ptr_nxt;
  logic [MAX_REQ-1:0] elig_ext;
  logic [MAX_REQ-1:0] pick_ext;

  always_comb begin
    elig_ext                = '0;
    elig_ext[NUM_REQ-1:0]   = eligible;
    pick_ext                = rr_pick(elig_ext, 4'(rr_ptr));
    pick                    = enable ? pick_ext[NUM_REQ-1:0] : '0;
    // Pointer follows the winner; bits at or above NUM_REQ are never set.
    ptr_nxt = rr_ptr;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick_ext[i]) ptr_nxt = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (enable) begin
      rr_ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/hw_semaphore.sv
// hw_semaphore: counting semaphore handing out a pool of NUM_TOKENS tokens to
// NUM_REQ requesters, at most one new grant per cycle, round-robin.
//   clk, reset_n   clock and asynchronous active-low reset
//   req            level request per requester
//   rel            one-cycle release pulse per requester
//   grant          level: requester holds a token
//   avail          number of free tokens
//   rel_err        registered pulse: a release came from a non-holder
//   grant_count    saturating count of grants      (HW_SEMAPHORE_STATS_EN)
//   contend_count  saturating count of starved cycles (HW_SEMAPHORE_STATS_EN)
// Handshake: a requester raises req and holds it until grant rises; grant then
// stays high, regardless of req, until the requester pulses rel. Dropping req
// before grant withdraws the request.
// Optional feature macro: HW_SEMAPHORE_STATS_EN.
module hw_semaphore
  import hw_semaphore_pkg::*;
#(
  parameter int NUM_REQ    = HW_SEM_NUM_REQ_DEF,
  parameter int NUM_TOKENS = HW_SEM_NUM_TOKENS_DEF,
  parameter int CW         = $clog2(NUM_TOKENS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  output logic [NUM_REQ-1:0] grant,
  output logic [CW-1:0]      avail,
  output logic               rel_err
`ifdef HW_SEMAPHORE_STATS_EN
  ,
  output logic [STATS_W-1:0] grant_count,
  output logic [STATS_W-1:0] contend_count
`endif
);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] valid_rel;
  logic               granted;
  logic               bad_rel;
  int                 rel_cnt;
  logic [CW-1:0]      avail_nxt;

  always_comb begin
    eligible  = req & ~grant;
    valid_rel = rel & grant;
    bad_rel   = |(rel & ~grant);
    granted   = |pick;
    rel_cnt   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rel_cnt = rel_cnt + int'(valid_rel[i]);
    end
    // Only holders can release and only a free token can be granted, so the
    // result stays within 0..NUM_TOKENS.
    avail_nxt = CW'(int'(avail) - int'(granted) + rel_cnt);
  end

  // Arbitration sees registered avail: a token freed at this edge is only
  // grantable from the next one.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .eligible (eligible),
    .enable   (avail != '0),
    .pick     (pick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant   <= '0;
      avail   <= CW'(NUM_TOKENS);
      rel_err <= 1'b0;
    end else begin
      grant   <= (grant & ~valid_rel) | pick;
      avail   <= avail_nxt;
      rel_err <= bad_rel;
    end
  end

`ifdef HW_SEMAPHORE_STATS_EN
  logic contended;
  assign contended = (|eligible) && (avail == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_count   <= '0;
      contend_count <= '0;
    end else begin
      if (granted && (grant_count != '1)) grant_count <= grant_count + STATS_W'(1);
      if (contended && (contend_count != '1)) contend_count <= contend_count + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hw_semaphore.sv
// tb_hw_semaphore: directed table, hand-written reset/regrant sequence and a
// randomized run against a token-pool reference model.
module tb_hw_semaphore;
  import hw_semaphore_pkg::*;

  localparam int N  = 4;
  localparam int T  = 2;
  localparam int CW = $clog2(T + 1);

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] rel = '0;
  logic [N-1:0] grant;
  logic [CW-1:0] avail;
  logic         rel_err;
`ifdef HW_SEMAPHORE_STATS_EN
  logic [STATS_W-1:0] grant_count;
  logic [STATS_W-1:0] contend_count;
`endif

  always #5 clk = ~clk;

  hw_semaphore #(.NUM_REQ(N), .NUM_TOKENS(T)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .rel           (rel),
    .grant         (grant),
    .avail         (avail),
    .rel_err       (rel_err)
`ifdef HW_SEMAPHORE_STATS_EN
    ,
    .grant_count   (grant_count),
    .contend_count (contend_count)
`endif
  );

  // ---------------- reference model ----------------
  // A set of holders, a free-token count and the index that gets first look.
  logic [N-1:0] m_held;
  int           m_avail;
  int           m_ptr;
  logic         m_err;
  int           m_grants;
  int           m_contend;

  task automatic model_reset();
    m_held = '0; m_avail = T; m_ptr = 0; m_err = 1'b0;
    m_grants = 0; m_contend = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
    int   winner;
    int   nrel;
    logic err;
    winner = -1; nrel = 0; err = 1'b0;
    if (m_avail > 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (winner < 0 && r[j] && !m_held[j]) winner = j;
      end
    end
    if (((r & ~m_held) != '0) && m_avail == 0) m_contend++;
    for (int i = 0; i < N; i++) begin
      if (l[i]) begin
        if (m_held[i]) begin m_held[i] = 1'b0; nrel++; end
        else err = 1'b1;
      end
    end
    if (winner >= 0) begin
      m_held[winner] = 1'b1;
      m_ptr = (winner + 1) % N;
      m_grants++;
    end
    m_avail = m_avail - ((winner >= 0) ? 1 : 0) + nrel;
    m_err = err;
  endtask

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popcount(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; applies inputs, steps the model at the edge and
  // returns at the next posedge+1 where outputs are sampled.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l);
    req = r; rel = l;
    @(posedge clk);
    model_step(r, l);
    #1;
    check("invariant", 32'(int'(avail) + popcount(grant)), 32'(T));
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] rel;
    logic [N-1:0] grant;
    int           avail;
    logic         err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] l;

    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 1, 1'b0};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0011, 0, 1'b0};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0011, 0, 1'b0};
    vecs[3]  = '{4'b1111, 4'b0001, 4'b0010, 1, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0110, 0, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1000, 4'b0110, 0, 1'b1};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0110, 0, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0100, 4'b0010, 1, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0010, 4'b1000, 1, 1'b0};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b1001, 0, 1'b0};
    vecs[10] = '{4'b0000, 4'b0000, 4'b1001, 0, 1'b0};
    vecs[11] = '{4'b0000, 4'b1001, 4'b0000, 2, 1'b0};
    vecs[12] = '{4'b0100, 4'b0000, 4'b0100, 1, 1'b0};
    vecs[13] = '{4'b0110, 4'b0000, 4'b0110, 0, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_avail", 32'(avail), 32'(T));
    check("reset_rel_err", 32'(rel_err), 32'd0);
    reset_n = 1'b1;

    // ---- directed table ----
    for (int v = 0; v < 14; v++) begin
      cycle(vecs[v].req, vecs[v].rel);
      check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].grant));
      check($sformatf("vec%0d_avail", v), 32'(avail), 32'(vecs[v].avail));
      check($sformatf("vec%0d_rel_err", v), 32'(rel_err), 32'(vecs[v].err));
    end

    // ---- asynchronous reset mid-stream (grant = 0110) ----
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_avail", 32'(avail), 32'(T));
    check("async_rst_rel_err", 32'(rel_err), 32'd0);
    model_reset();
    #1;
    reset_n = 1'b1;
    cycle(4'b1111, 4'b0000);
    check("post_rst_first_grant", 32'(grant), 32'b0001);

    // ---- release and re-request at the same edge ----
    cycle(4'b0001, 4'b0001);
    check("rel_req_same_grant", 32'(grant), 32'b0000);
    check("rel_req_same_avail", 32'(avail), 32'(T));
    cycle(4'b0001, 4'b0000);
    check("regrant_grant", 32'(grant), 32'b0001);
    check("regrant_avail", 32'(avail), 32'd1);

    // ---- randomized run against the model ----
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      l = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 2) != 0) l = '0;
      else if ($urandom_range(0, 5) != 0) l = l & m_held;
      cycle(r, l);
      check("rand_grant", 32'(grant), 32'(m_held));
      check("rand_avail", 32'(avail), 32'(m_avail));
      check("rand_rel_err", 32'(rel_err), 32'(m_err));
`ifdef HW_SEMAPHORE_STATS_EN
      check("rand_grant_count", grant_count, 32'(m_grants));
      check("rand_contend_count", contend_count, 32'(m_contend));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hw_semaphore.md
# hw_semaphore

Counting hardware semaphore that arbitrates a fixed pool of tokens among several requesters, granting round-robin one token per cycle. Sits directly downstream of the Teal-driven test top: the C++ threads drive `req`/`rel` pins through the top, and this block produces the `grant` levels they wait on. It is the hardware side of the semaphore test, with `test_done` raised by Teal once grant traffic is checked.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `NUM_TOKENS`, 2, tokens in the pool (1..NUM_REQ)
- `CW`, $clog2(NUM_TOKENS+1), width of token count
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  level request per requester
- `rel`  in  NUM_REQ  one-cycle release pulse per requester
- `grant`  out  NUM_REQ  level: requester i holds a token
- `avail`  out  CW  tokens currently free
- `rel_err`  out  1  one-cycle pulse: release from a non-holder
- `grant_count`  out  32  total grants issued (only with HW_SEMAPHORE_STATS_EN)
- `contend_count`  out  32  cycles with a waiter and avail==0 (only with HW_SEMAPHORE_STATS_EN)

## Operation
- Per-requester state, implicit in `grant[i]` and `req[i]`: IDLE (req=0, grant=0) -> WAIT (req=1, grant=0) -> HELD (grant=1) -> IDLE on `rel[i]`.
- Eligible set: `req[i] & ~grant[i]`. A holder never receives a second token.
- Each cycle with `avail > 0` and a non-empty eligible set, exactly one requester is granted: the first eligible at or after `rr_ptr`, wrapping modulo NUM_REQ. `rr_ptr` then moves to granted index + 1, wrapping NUM_REQ-1 -> 0.
- `rel[i]` with `grant[i]==1`: `grant[i]` clears and the token returns to the pool.
- `rel[i]` with `grant[i]==0`: ignored; `rel_err` pulses; `avail` unchanged.
- Dropping `req[i]` while HELD has no effect. Only `rel` frees a token. Dropping `req[i]` while WAIT withdraws the request with no grant.
- Count update: `avail_next = avail - granted + released`, where `granted` is 0/1 and `released` is 0..NUM_REQ. Never exceeds NUM_TOKENS and never underflows. Invariant: `avail + popcount(grant) == NUM_TOKENS`.
- Multiple simultaneous valid releases are all accepted in the same cycle.

## Timing
- Reset values: `grant`=0, `avail`=NUM_TOKENS, `rel_err`=0, `rr_ptr`=0, stats counters=0.
- Grant latency: `req[i]` sampled high at edge N with a token free and i winning -> `grant[i]` high after edge N, visible in cycle N+1.
- Arbitration uses registered `avail`, so a token released at edge N is grantable at edge N+1 at the earliest.
- Release and grant in the same cycle by different requesters: both take effect and `avail` is unchanged.
- `rel[i]` and `req[i]` high together while HELD: the token is released at that edge. Re-grant to i is possible at the next edge if it still requests.
- `rel_err` is registered and asserts the cycle after the offending `rel`.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously) and outstanding holders lose their tokens silently.

## Configuration
- `HW_SEMAPHORE_STATS_EN` defined: `grant_count` and `contend_count` ports and registers exist. Both are 32-bit saturating counters, cleared by reset.
- `HW_SEMAPHORE_STATS_EN` undefined: those ports and registers are absent. Grant behaviour is identical.

## Structure
- Package `hw_semaphore_pkg` holds the default constants `HW_SEM_NUM_REQ_DEF` and `HW_SEM_NUM_TOKENS_DEF`, the `STATS_W`=32 constant, and the function `rr_pick(eligible, ptr)`.
- One sub-module: `rr_arbiter` (NUM_REQ). Input: eligible vector, enable. Output: one-hot pick. It owns `rr_ptr`. `hw_semaphore` keeps the token count, the grant register and error detection.

## Test plan
- Reset, then NUM_TOKENS=2 and `req`=4'b1111 from cycle 1 -> `grant` 4'b0001 at cycle 2, then 4'b0011 at cycle 3. `avail` goes 2 -> 1 -> 0, and no further grant.
- With `grant`=4'b0011, pulse `rel`=4'b0001 -> `grant` 4'b0010, then req2 granted the next cycle, giving 4'b0110 (round-robin skips 0). `avail` stays 0.
- `rel`=4'b1000 while `grant[3]`=0 -> `rel_err` pulses for 1 cycle, `avail` and `grant` unchanged.
- `rel` on requester 1 and new grant to requester 3 at the same edge -> `avail` constant. The invariant `avail + popcount(grant)==2` holds every cycle.
- Assert `reset_n`=0 mid-stream with `grant`=4'b0110 -> `grant`=0 and `avail`=2 without a clock edge. After release, the first grant goes to requester 0.
- With HW_SEMAPHORE_STATS_EN, 10 grants and 7 contended cycles -> `grant_count`=10, `contend_count`=7.
